// File: rtl/bc_clr_en_reg_rr_arbiter.sv
// Round-robin arbitrated access to one shared clear/enable register.
// Grant is combinational and the register, update strobe, source tag and saturating counter are registered.
module bc_clr_en_reg_rr_arbiter #(
    parameter int               NUM_REQ  = 4,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1),
    parameter int               CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iClrAll,
    input  logic [NUM_REQ-1:0]         iReqVld,
    input  logic [NUM_REQ-1:0]         iReqClr,
    input  logic [NUM_REQ*WIDTH-1:0]   iReqDat,
    output logic [NUM_REQ-1:0]         oReqRdy,
    output logic [$clog2(NUM_REQ)-1:0] oGntIdx,
    output logic [WIDTH-1:0]           oDat,
    output logic                       oUpdVld,
    output logic [$clog2(NUM_REQ):0]   oUpdSrc,
    output logic [CNT_W-1:0]           oUpdCnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SRC_W = IDX_W + 1;

    // Handshake: requester k presents iReqVld[k] with iReqClr[k]/iReqDat[k]; a transfer
    // happens in any cycle where iReqVld[k] & oReqRdy[k]. Valid may drop without ready.
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             upd_vld_q, upd_vld_d;
    logic [SRC_W-1:0] upd_src_q, upd_src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [WIDTH-1:0] gnt_dat;
    logic             gnt_clr;
    logic             xfer;

    // Search starts at the pointer and wraps, so the last winner has lowest priority.
    always_comb begin
        cand      = 0;
        cand_idx  = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!gnt_found && iReqVld[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        gnt_oh  = '0;
        gnt_dat = '0;
        gnt_clr = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                gnt_oh[k] = 1'b1;
                gnt_dat   = iReqDat[k*WIDTH +: WIDTH];
                gnt_clr   = iReqClr[k];
            end
        end
    end

    assign oReqRdy = (gnt_found && !iClrAll && !rst) ? gnt_oh : '0;
    assign oGntIdx = gnt_idx;
    assign xfer    = |(oReqRdy & iReqVld);

    // A global clear beats any requester and leaves the round-robin pointer alone.
    always_comb begin
        ptr_d     = ptr_q;
        dat_d     = dat_q;
        upd_vld_d = 1'b0;
        upd_src_d = upd_src_q;
        cnt_d     = cnt_q;
        if (iClrAll) begin
            dat_d     = INI_DATA;
            upd_vld_d = 1'b1;
            upd_src_d = SRC_W'(NUM_REQ);
        end else if (xfer) begin
            dat_d     = gnt_clr ? INI_DATA : gnt_dat;
            upd_vld_d = 1'b1;
            upd_src_d = {1'b0, gnt_idx};
            ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
        if (upd_vld_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            dat_q     <= INI_DATA;
            upd_vld_q <= 1'b0;
            upd_src_q <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            dat_q     <= dat_d;
            upd_vld_q <= upd_vld_d;
            upd_src_q <= upd_src_d;
            cnt_q     <= cnt_d;
        end
    end

    assign oDat    = dat_q;
    assign oUpdVld = upd_vld_q;
    assign oUpdSrc = upd_src_q;
    assign oUpdCnt = cnt_q;

endmodule

// File: tb/tb_bc_clr_en_reg_rr_arbiter.sv
// Directed and random stimulus for the shared-register arbiter, with a reference model
// feeding an expected-update queue that is drained whenever the DUT strobes oUpdVld.
module tb_bc_clr_en_reg_rr_arbiter;

    localparam int          NUM_REQ = 4;
    localparam int          WIDTH   = 32;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] INI     = 32'h1;
    localparam int          CNT_MAX = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         iClrAll;
    logic [3:0]   iReqVld;
    logic [3:0]   iReqClr;
    logic [127:0] iReqDat;
    logic [3:0]   oReqRdy;
    logic [1:0]   oGntIdx;
    logic [31:0]  oDat;
    logic         oUpdVld;
    logic [2:0]   oUpdSrc;
    logic [3:0]   oUpdCnt;

    bc_clr_en_reg_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .INI_DATA(INI),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iClrAll(iClrAll),
        .iReqVld(iReqVld),
        .iReqClr(iReqClr),
        .iReqDat(iReqDat),
        .oReqRdy(oReqRdy),
        .oGntIdx(oGntIdx),
        .oDat   (oDat),
        .oUpdVld(oUpdVld),
        .oUpdSrc(oUpdSrc),
        .oUpdCnt(oUpdCnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [36:0] exp_q[$];

    int          m_ptr;
    int          m_cnt;
    int          m_g;
    bit          m_found;
    bit          started = 1'b0;
    logic [31:0] m_dat;
    logic [31:0] m_d;
    logic [36:0] m_e;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare what the last edge produced, then predict the coming edge from the
    // inputs, which are stable from just after posedge until the next posedge.
    always @(negedge clk) begin
        if (started) begin
            check("sb_upd_vld", {36'd0, oUpdVld}, {36'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                m_e = exp_q.pop_front();
                check("sb_upd", {oUpdSrc, oDat}, m_e);
            end
            check("model_dat", {5'd0, oDat}, {5'd0, m_dat});
            check("model_cnt", {33'd0, oUpdCnt}, 37'(m_cnt));
        end
        if (rst) begin
            exp_q.delete();
            m_ptr = 0;
            m_cnt = 0;
            m_dat = INI;
        end else if (iClrAll) begin
            exp_q.push_back({3'd4, INI});
            m_dat = INI;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_found = 1'b0;
            m_g     = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!m_found && iReqVld[(m_ptr + i) % NUM_REQ]) begin
                    m_found = 1'b1;
                    m_g     = (m_ptr + i) % NUM_REQ;
                end
            end
            if (m_found) begin
                m_d = iReqClr[m_g] ? INI : iReqDat[m_g*32 +: 32];
                exp_q.push_back({3'(m_g), m_d});
                m_dat = m_d;
                m_ptr = (m_g + 1) % NUM_REQ;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
        started = 1'b1;
    end

    initial begin
        logic [3:0] e_oh;

        rst     = 1'b1;
        iClrAll = 1'b0;
        iReqVld = 4'hF;
        iReqClr = 4'h0;
        iReqDat = '0;

        // Reset holds off grants even with every requester valid.
        tick();
        check("t1_rdy_in_rst", {33'd0, oReqRdy}, 37'd0);
        tick();
        check("t1_rdy_in_rst2", {33'd0, oReqRdy}, 37'd0);
        check("t1_dat", {5'd0, oDat}, {5'd0, 32'h1});
        check("t1_cnt", {33'd0, oUpdCnt}, 37'd0);
        check("t1_vld", {36'd0, oUpdVld}, 37'd0);
        check("t1_src", {34'd0, oUpdSrc}, 37'd0);

        // Rotation with every requester valid.
        for (int k = 0; k < 4; k++) iReqDat[k*32 +: 32] = 32'hA0 + 32'(k);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            e_oh = 4'b0001 << (c % 4);
            check("t2_rdy", {33'd0, oReqRdy}, {33'd0, e_oh});
            check("t2_gnt", {35'd0, oGntIdx}, 37'(c % 4));
            tick();
            check("t2_dat", {5'd0, oDat}, {5'd0, 32'hA0 + 32'(c % 4)});
            check("t2_src", {34'd0, oUpdSrc}, 37'(c % 4));
        end
        check("t2_cnt", {33'd0, oUpdCnt}, 37'd8);

        // Skip and wrap: move pointer to 3, then alternate between 0 and 2.
        iReqVld = 4'b0100;
        #1;
        check("t3_rdy_setup", {33'd0, oReqRdy}, 37'b0100);
        tick();
        iReqVld = 4'b0101;
        #1;
        check("t3_rdy_wrap0", {33'd0, oReqRdy}, 37'b0001);
        tick();
        check("t3_dat0", {5'd0, oDat}, {5'd0, 32'hA0});
        check("t3_rdy_2", {33'd0, oReqRdy}, 37'b0100);
        tick();
        check("t3_dat2", {5'd0, oDat}, {5'd0, 32'hA2});
        check("t3_rdy_0b", {33'd0, oReqRdy}, 37'b0001);
        tick();

        // Global clear beats a pending request and leaves the pointer at 1.
        iReqVld = 4'b0001;
        iReqDat[31:0] = 32'h55;
        tick();
        check("t4_dat55", {5'd0, oDat}, {5'd0, 32'h55});
        iClrAll = 1'b1;
        iReqVld = 4'h2;
        #1;
        check("t4_rdy_clrall", {33'd0, oReqRdy}, 37'd0);
        tick();
        check("t4_dat_ini", {5'd0, oDat}, {5'd0, 32'h1});
        check("t4_src", {34'd0, oUpdSrc}, 37'd4);
        check("t4_vld", {36'd0, oUpdVld}, 37'd1);
        iClrAll = 1'b0;
        iReqVld = 4'b1010;
        #1;
        check("t4_rdy_after", {33'd0, oReqRdy}, 37'b0010);
        check("t4_gnt_after", {35'd0, oGntIdx}, 37'd1);
        tick();
        check("t4_dat_req1", {5'd0, oDat}, {5'd0, 32'hA1});

        // Per-requester clear ignores its data.
        iReqVld = 4'b0100;
        iReqClr = 4'b0100;
        iReqDat[64 +: 32] = 32'hDEAD;
        #1;
        check("t5_rdy", {33'd0, oReqRdy}, 37'b0100);
        tick();
        check("t5_dat", {5'd0, oDat}, {5'd0, 32'h1});
        check("t5_src", {34'd0, oUpdSrc}, 37'd2);
        iReqVld = 4'h0;
        iReqClr = 4'h0;
        #1;
        check("t5_rdy_idle", {33'd0, oReqRdy}, 37'd0);
        tick();
        check("t5_vld_idle", {36'd0, oUpdVld}, 37'd0);
        check("t5_dat_hold", {5'd0, oDat}, {5'd0, 32'h1});

        // Counter saturation.
        rst = 1'b1;
        tick();
        check("t6_cnt_rst", {33'd0, oUpdCnt}, 37'd0);
        rst = 1'b0;
        iReqVld = 4'hF;
        for (int i = 0; i < 20; i++) tick();
        check("t6_cnt_sat", {33'd0, oUpdCnt}, 37'd15);
        iReqVld = 4'h0;
        iClrAll = 1'b1;
        tick();
        check("t6_cnt_hold", {33'd0, oUpdCnt}, 37'd15);
        iClrAll = 1'b0;

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            iReqVld = 4'($urandom_range(0, 15));
            iReqClr = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) iReqDat[k*32 +: 32] = $urandom();
            iClrAll = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 79) == 0);
            tick();
        end

        rst     = 1'b0;
        iClrAll = 1'b0;
        iReqVld = 4'h0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
